// File: rtl/mem_wb_stage_mc.sv
// Memory/write-back stage with multi-cycle data memory, byte-lane stores and formatted loads.
// Latency: 1 cycle for non-memory ops; MEM_LATENCY+2 cycles for memory ops.
// Backpressure: stall_MEM holds upstream for MEM_LATENCY+1 cycles per good memory op; bad ops never stall.
module mem_wb_stage_mc #(
   parameter int WIDTH       = 32,
   parameter int SIZE        = 256,
   parameter int MEM_LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_EXMEM,
   input  logic [WIDTH-1:0] ALU_out_EXMEM,
   input  logic [2:0]       funct3_EXMEM,
   input  logic             mem_rd_en_EXMEM,
   input  logic             mem_wr_en_EXMEM,
   input  logic [WIDTH-1:0] rs2_data_EXMEM,
   input  logic             reg_wr_en_EXMEM,
   input  logic [1:0]       reg_wr_ctrl_EXMEM,
   input  logic [4:0]       rd_EXMEM,
   input  logic [WIDTH-1:0] pc_4_EXMEM,
   output logic             stall_MEM,
   output logic             valid_WBID,
   output logic [WIDTH-1:0] reg_wr_data_WBID,
   output logic [4:0]       rd_WBID,
   output logic             reg_wr_en_WBID,
   output logic             misaligned_MEM
);

   localparam int LOGSIZE = $clog2(SIZE);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t             state, state_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic [WIDTH-1:0]   mem [SIZE];

   logic [1:0]         lane;
   logic [LOGSIZE-1:0] widx;
   logic               mem_op, bad;
   logic               wb_take, bad_evt, commit_wr;
   logic [3:0]         be;
   logic [WIDTH-1:0]   wdata, rdata, load_fmt, wb_data;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;

   assign lane   = ALU_out_EXMEM[1:0];
   assign widx   = ALU_out_EXMEM[LOGSIZE+1:2];
   assign mem_op = valid_EXMEM & (mem_rd_en_EXMEM | mem_wr_en_EXMEM);

   // Classify the access: misaligned halfword/word or an undefined funct3 for the direction.
   always_comb begin
      bad = 1'b0;
      if (mem_rd_en_EXMEM) begin
         case (funct3_EXMEM)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lane[0];
            3'b010:         bad = |lane;
            default:        bad = 1'b1;
         endcase
      end else begin
         case (funct3_EXMEM)
            3'b000:  bad = 1'b0;
            3'b001:  bad = lane[0];
            3'b010:  bad = |lane;
            default: bad = 1'b1;
         endcase
      end
   end

   // Store lane enables and lane-replicated store data.
   always_comb begin
      be    = 4'b1111;
      wdata = rs2_data_EXMEM;
      case (funct3_EXMEM[1:0])
         2'b00: begin
            be    = 4'b0001 << lane;
            wdata = {4{rs2_data_EXMEM[7:0]}};
         end
         2'b01: begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rs2_data_EXMEM[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = rs2_data_EXMEM;
         end
      endcase
   end

   // Load extraction and sign/zero extension, then the write-back source mux.
   always_comb begin
      rdata    = mem[widx];
      byte_sel = rdata[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
      case (funct3_EXMEM)
         3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_fmt = {24'd0, byte_sel};
         3'b101:  load_fmt = {16'd0, half_sel};
         default: load_fmt = rdata;
      endcase
      case (reg_wr_ctrl_EXMEM)
         2'd0:    wb_data = ALU_out_EXMEM;
         2'd1:    wb_data = pc_4_EXMEM;
         2'd2:    wb_data = load_fmt;
         default: wb_data = '0;
      endcase
   end

   // FSM next state, wait-state counter and stall / write-back decisions.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_MEM = 1'b0;
      wb_take   = 1'b0;
      bad_evt   = 1'b0;
      commit_wr = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op && !bad) begin
               stall_MEM = 1'b1;
               state_nxt = ACCESS;
               cnt_nxt   = 4'(MEM_LATENCY);
            end else if (mem_op) begin
               bad_evt = 1'b1;
            end else begin
               wb_take = valid_EXMEM;
            end
         end
         ACCESS: begin
            if (cnt != 4'd0) begin
               stall_MEM = 1'b1;
               cnt_nxt   = cnt - 4'd1;
            end else begin
               wb_take   = valid_EXMEM;
               commit_wr = valid_EXMEM & mem_wr_en_EXMEM;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Data memory write on the final access cycle; a reset in that cycle drops the store.
   always_ff @(posedge clk) begin
      if (!rst && commit_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Write-back register and the one-cycle exception pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_WBID       <= 1'b0;
         reg_wr_data_WBID <= '0;
         rd_WBID          <= 5'd0;
         reg_wr_en_WBID   <= 1'b0;
         misaligned_MEM   <= 1'b0;
      end else begin
         valid_WBID     <= wb_take;
         reg_wr_en_WBID <= wb_take & reg_wr_en_EXMEM;
         misaligned_MEM <= bad_evt;
         if (wb_take) begin
            reg_wr_data_WBID <= wb_data;
            rd_WBID          <= rd_EXMEM;
         end
      end
   end

endmodule

// File: doc/mem_wb_stage_mc.md
# mem_wb_stage_mc

Pipelined, parametrised successor to the single-cycle memory/write-back stage. It sits between the EX/MEM pipeline register and the register-file write port (ID). Data memory has a configurable access latency, so the block runs a small FSM with a wait-state counter and raises a stall to upstream stages while an access is in flight. It also detects misaligned and illegal accesses, handles byte-lane stores and sign/zero-extended loads, and registers the write-back result.

## Interface
- WIDTH, 32: bits per word; fixed at 32.
- SIZE, 256: data memory depth in words (power of two); LOGSIZE = $clog2(SIZE).
- MEM_LATENCY, 2: wait-state cycles per memory access; legal range 0..15.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_EXMEM  in  1  instruction present on EX/MEM inputs.
- ALU_out_EXMEM  in  32  byte address for loads/stores; ALU result otherwise.
- funct3_EXMEM  in  3  load/store size and sign (RV32I encoding).
- mem_rd_en_EXMEM  in  1  load.
- mem_wr_en_EXMEM  in  1  store; never asserted together with mem_rd_en_EXMEM.
- rs2_data_EXMEM  in  32  store data.
- reg_wr_en_EXMEM  in  1  register write request.
- reg_wr_ctrl_EXMEM  in  2  write-back source: 0 ALU, 1 pc+4, 2 load data, 3 zero.
- rd_EXMEM  in  5  destination register.
- pc_4_EXMEM  in  32  PC+4.
- stall_MEM  out  1  upstream must hold all *_EXMEM inputs stable.
- valid_WBID  out  1  registered: a write-back slot is valid.
- reg_wr_data_WBID  out  32  registered write data.
- rd_WBID  out  5  registered destination register.
- reg_wr_en_WBID  out  1  registered; equals reg_wr_en & valid.
- misaligned_MEM  out  1  registered one-cycle exception pulse.

## Operation
- Memory is a word array of SIZE words. Word index is addr[LOGSIZE+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
- Memory contents are not reset.
- Memory op = valid_EXMEM & (mem_rd_en_EXMEM | mem_wr_en_EXMEM).
- A memory op is bad when any of these holds:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - funct3 outside {LB, LH, LW, LBU, LHU} for loads or {SB, SH, SW} for stores.
- FSM states are IDLE and ACCESS. A 4-bit counter cnt is used in ACCESS.
- IDLE:
  - Non-memory valid op: WB register loads the write-back result next edge; stall_MEM=0.
  - Bad memory op: no memory access. Next edge: misaligned_MEM=1, valid_WBID=0, reg_wr_en_WBID=0 (bubble). stall_MEM=0.
  - Good memory op: stall_MEM=1 (combinational). Next edge: state→ACCESS, cnt←MEM_LATENCY, valid_WBID←0.
  - valid_EXMEM=0: next edge valid_WBID=0, reg_wr_en_WBID=0.
- ACCESS with cnt≠0: stall_MEM=1, cnt decrements, valid_WBID←0.
- ACCESS with cnt=0: stall_MEM=0. On this edge:
  - Store commits with byte enables: SB lane addr[1:0], SH lanes {addr[1],x}, SW all lanes.
  - Load data is formatted and written into the WB register.
  - State→IDLE.
- Load formatting: LB/LH sign-extend the selected byte/halfword; LBU/LHU zero-extend it; LW passes the word.
- Store data: SB replicates rs2[7:0] into the selected lane; SH places rs2[15:0] into the selected halfword.
- Write-back mux: ctrl 0 → ALU_out, 1 → pc_4, 2 → formatted load data, 3 → 0.

## Timing
- Non-memory op: 1-cycle latency to WB outputs, no stall.
- Memory op: occupies MEM_LATENCY+2 cycles, of which stall_MEM=1 for MEM_LATENCY+1. WB outputs are valid the cycle after the final ACCESS cycle.
- MEM_LATENCY=0: exactly 1 stall cycle, and the result appears 2 cycles after the op is presented.
- Back-to-back memory ops: the second op is evaluated in the IDLE cycle right after the first op's final ACCESS edge. There are no idle gaps beyond that.
- A store followed immediately by a load to the same word returns the newly stored data.
- Reset values: state=IDLE, cnt=0, stall_MEM=0, valid_WBID=0, reg_wr_data_WBID=0, rd_WBID=0, reg_wr_en_WBID=0, misaligned_MEM=0.
- Reset during ACCESS: the op is abandoned, the pending store is not committed, and no WB output is produced.
- misaligned_MEM is high for exactly 1 cycle per bad op.

## Test plan
- MEM_LATENCY=2. SW 0xDEADBEEF @0x10, then LW @0x10 with ctrl=2, rd=5 → stall_MEM high 3 cycles per op; rd_WBID=5, reg_wr_data_WBID=0xDEADBEEF, valid=1, 1 cycle after the load's final ACCESS cycle.
- After that store: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x12 → 0xFFFFDEAD; LHU @0x10 → 0x0000BEEF.
- SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 → 0xDEAD55EF. SH 0x1234 @0x12, then LW → 0x123455EF.
- LW @0x12 and SH @0x11 → misaligned_MEM 1-cycle pulse, no stall, valid_WBID=0; the following LW @0x10 still reads 0x123455EF.
- Non-memory ops: ctrl=0 with ALU_out=7 → data 7, 1-cycle latency. ctrl=1 with pc_4=0x104 → 0x104. ctrl=3 → 0.
- MEM_LATENCY=0 back-to-back LW/LW. Separately, assert rst mid-ACCESS of SW 0x1 @0x20 → all outputs 0 the next cycle; a subsequent LW @0x20 returns the old contents.
